// File: rtl/seq_shifter.sv
// Multi-cycle 32-bit shifter: one bit per clock through a single right-shifting work register.
// Left shifts run as right shifts on the bit-reversed operand, and the result is reversed back.
module seq_shifter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  shamt,
  input  logic [31:0] A,
  output logic [31:0] R,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] work_reg;
  logic [31:0] result_reg;
  logic [4:0]  cnt_reg;
  logic [1:0]  op_reg;
  logic        sign_reg;

  logic [31:0] a_rev;
  logic [31:0] shifted;
  logic [31:0] shifted_rev;
  logic [31:0] result;
  logic        fill;

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_rev
      assign a_rev[gi]       = A[31-gi];
      assign shifted_rev[gi] = shifted[31-gi];
    end
  endgenerate

  always_comb begin
    fill = 1'b0;
    case (op_reg)
      OP_SRA:  fill = sign_reg;
      OP_ROR:  fill = work_reg[0];
      default: fill = 1'b0;
    endcase
  end

  assign shifted = {fill, work_reg[31:1]};
  assign result  = (op_reg == OP_SLL) ? shifted_rev : shifted;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (shamt != 5'd0) ? SHIFT : DONE;
      SHIFT:   if (cnt_reg == 5'd1) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      work_reg   <= 32'd0;
      result_reg <= 32'd0;
      cnt_reg    <= 5'd0;
      op_reg     <= 2'b00;
      sign_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            work_reg <= (op == OP_SLL) ? a_rev : A;
            cnt_reg  <= shamt;
            op_reg   <= op;
            sign_reg <= A[31];
            // A zero shift skips SHIFT entirely, so the operand is the result
            if (shamt == 5'd0) result_reg <= A;
          end
        end
        SHIFT: begin
          work_reg <= shifted;
          cnt_reg  <= cnt_reg - 5'd1;
          if (cnt_reg == 5'd1) result_reg <= result;
        end
        default: ;
      endcase
    end
  end

  assign R    = result_reg;
  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed-vector bench for seq_shifter: result, latency, busy length, reset abort,
// start-ignored-while-busy and back-to-back acceptance.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] A;
  logic [31:0] R;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] last_r;

  seq_shifter dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .shamt (shamt),
    .A     (A),
    .R     (R),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE; optionally re-pulse start mid-operation with other operands.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [4:0] sh,
                        input logic [31:0] exp, input bit bump);
    int n;
    int bn;
    bit seen;
    @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
    chk("r_held", R, last_r);
    start = 1'b1;
    op    = o;
    A     = a;
    shamt = sh;
    n = 0;
    bn = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      start = bump && (n == 1);
      op    = ~o;
      A     = ~a ^ $urandom;
      shamt = sh ^ 5'd3;
      n++;
      if (busy) bn++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("result", R, exp);
    chk("latency", n, sh + 1);
    chk("busy_len", bn, sh + 1);
    $display("op=%0d A=%h shamt=%0d -> R=%h latency=%0d busy=%0d", o, a, sh, R, n, bn);
    last_r = exp;
  endtask

  initial begin
    int pulses;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    shamt = 5'd0;
    A     = 32'd0;
    last_r = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_R", R, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    run_op(2'b00, 32'h00000001, 5'd4,  32'h00000010, 1'b0);
    run_op(2'b01, 32'h80000000, 5'd31, 32'h00000001, 1'b0);
    run_op(2'b10, 32'h80000000, 5'd4,  32'hF8000000, 1'b0);
    run_op(2'b11, 32'h00000001, 5'd1,  32'h80000000, 1'b0);
    run_op(2'b11, 32'h12345678, 5'd8,  32'h78123456, 1'b0);
    run_op(2'b10, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0);
    run_op(2'b00, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 1'b0);
    run_op(2'b11, 32'hCAFEF00D, 5'd0,  32'hCAFEF00D, 1'b0);
    run_op(2'b00, 32'h80000001, 5'd31, 32'h80000000, 1'b0);
    run_op(2'b10, 32'h7FFFFFFF, 5'd31, 32'h00000000, 1'b0);
    run_op(2'b10, 32'hF0000000, 5'd31, 32'hFFFFFFFF, 1'b0);
    run_op(2'b11, 32'h80000001, 5'd31, 32'h00000003, 1'b0);
    run_op(2'b01, 32'h12345678, 5'd4,  32'h01234567, 1'b1);
    run_op(2'b00, 32'h12345678, 5'd8,  32'h34567800, 1'b1);

    // Abort an srl on its third SHIFT cycle; start held alongside reset must be ignored
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    A     = 32'hFFFFFFFF;
    shamt = 5'd10;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_R", R, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    $display("reset abort: R=%h busy=%0d activity_after=%0d", R, busy, pulses);
    last_r = 32'd0;
    run_op(2'b01, 32'hFFFFFFFF, 5'd10, 32'h003FFFFF, 1'b0);
    run_op(2'b10, 32'h80000000, 5'd4,  32'hF8000000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits and shift amount at 5 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  2  shift type: 00 sll, 01 srl, 10 sra, 11 ror (rotate right).
REQ-006 shamt  input  5  shift amount 0..31, captured with start.
REQ-007 A  input  32  operand, captured with start.
REQ-008 R  output  32  registered result; held stable until next accepted start or reset.
REQ-009 busy  output  1  high while an operation is in progress (SHIFT or DONE state).
REQ-010 done  output  1  one-cycle pulse marking R valid for the current operation.

Function
REQ-011 FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1: capture op, A, shamt into internal work register, op register and 5-bit down-counter; next state SHIFT if shamt!=0, else DONE.
REQ-013 sll SHALL be implemented by loading the bit-reversed operand (bit i <- A[31-i]), performing logical right shifts, and bit-reversing again when writing R.
REQ-014 Each SHIFT cycle SHALL shift the work register right by exactly one bit and decrement the counter by one.
REQ-015 Shift fill bit: sll/srl 0; sra the captured A[31]; ror the outgoing bit 0.
REQ-016 SHIFT -> DONE when counter equals 1 at the clock edge (last shift performed on that edge); otherwise stay in SHIFT.
REQ-017 DONE: R SHALL be loaded with the final result (re-reversed for sll) on the edge entering DONE; done=1 during the DONE cycle only; next state IDLE unconditionally.
REQ-018 Latency: done SHALL be high exactly shamt+1 cycles after the edge that sampled start (shamt=0 -> 1 cycle, shamt=31 -> 32 cycles).
REQ-019 shamt=0 SHALL return R=A for every op.
REQ-020 start asserted in SHIFT or DONE SHALL be ignored; captured operands SHALL NOT change mid-operation.
REQ-021 start asserted in the cycle immediately after DONE (state IDLE) SHALL be accepted normally; back-to-back operations incur no extra idle cycle beyond the IDLE cycle.
REQ-022 op, A, shamt changes while busy SHALL have no effect on the result.
REQ-023 busy SHALL be 0 in IDLE and 1 in SHIFT and DONE.

Reset
REQ-024 reset=1 at a clock edge SHALL force state IDLE, R=0x00000000, busy=0, done=0, counter=0, work register=0.
REQ-025 reset SHALL take priority over start and over any in-progress operation; an aborted operation SHALL NOT produce a done pulse.
REQ-026 start asserted in the same cycle as reset SHALL be ignored.

Verification
REQ-027 sll A=0x00000001 shamt=4 -> R=0x00000010, done high 5 cycles after start sampled, busy high 5 cycles.
REQ-028 srl A=0x80000000 shamt=31 -> R=0x00000001, done 32 cycles after start; sra A=0x80000000 shamt=4 -> R=0xF8000000.
REQ-029 ror A=0x00000001 shamt=1 -> R=0x80000000; ror A=0x12345678 shamt=8 -> R=0x78123456.
REQ-030 shamt=0, op=sra, A=0xDEADBEEF -> R=0xDEADBEEF, done 1 cycle after start.
REQ-031 srl A=0xFFFFFFFF shamt=10, reset pulsed on 3rd SHIFT cycle -> busy=0, R=0, no done pulse; following start accepted and completes correctly.
REQ-032 start re-asserted with different A/shamt during SHIFT -> ignored; R matches original request; start in the cycle after done -> accepted.
